// File: rtl/rx_phase_pkg.sv
// Shared definitions for the RX sampling-phase acquisition controller:
// FSM state encoding and default window sizing.
package rx_phase_pkg;

  // State encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_SETTLE  = S_SETTLE,
    ST_MEASURE = S_MEASURE,
    ST_EVAL    = S_EVAL,
    ST_LOCKED  = S_LOCKED,
    ST_CHECK   = S_CHECK
  } state_t;

  // Default window sizing
  localparam int DEF_SETTLE_BITS = 1024;
  localparam int DEF_WINDOW_BITS = 4096;
  localparam int DEF_LOCK_THRESH = 16;
  localparam int DEF_NB_WIN      = 32;

endpackage

// File: rtl/rx_phase_ctrl_bit_window.sv
// Bit-window tracker: snapshots the cumulative BER counters and reports the
// bit/error deltas since the snapshot. Deltas use modular subtraction so a
// counter wrap between snapshot and now needs no special handling.
module bit_window
  import rx_phase_pkg::*;
#(
  parameter int NB_COUNT = 64,
  parameter int NB_WIN   = DEF_NB_WIN
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_snap,
  input  logic [NB_COUNT-1:0] i_bit_count,
  input  logic [NB_COUNT-1:0] i_error_count,
  input  logic [NB_WIN-1:0]   i_target,
  output logic                o_done,
  output logic [NB_WIN-1:0]   o_err
);

  logic [NB_COUNT-1:0] bit_base;
  logic [NB_COUNT-1:0] err_base;
  logic [NB_WIN-1:0]   bit_win;

  // Latch the counter base whenever a new window starts
  always_ff @(posedge clock) begin
    if (i_reset) begin
      bit_base <= '0;
      err_base <= '0;
    end else if (i_snap) begin
      bit_base <= i_bit_count;
      err_base <= i_error_count;
    end
  end

  // Deltas are taken modulo 2^NB_COUNT, then truncated to the window width
  assign bit_win = NB_WIN'(i_bit_count - bit_base);
  assign o_err   = NB_WIN'(i_error_count - err_base);
  assign o_done  = (bit_win >= i_target);

endmodule

// File: rtl/rx_phase_ctrl.sv
// RX sampling-phase acquisition controller. Sweeps every RX buffer offset,
// scores each over a fixed bit window using the BER counters, locks the
// offset with the fewest errors and re-acquires if the locked error rate
// degrades past a threshold. All outputs are registered.
module rx_phase_ctrl
  import rx_phase_pkg::*;
#(
  parameter int NB_COUNT    = 64,
  parameter int NB_OFF      = 2,
  parameter int SETTLE_BITS = DEF_SETTLE_BITS,
  parameter int WINDOW_BITS = DEF_WINDOW_BITS,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int NB_WIN      = DEF_NB_WIN
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_COUNT-1:0] i_error_count,
  input  logic [NB_COUNT-1:0] i_bit_count,
  output logic [NB_OFF-1:0]   o_offset,
  output logic                o_rx_enable,
  output logic                o_busy,
  output logic                o_locked,
  output logic [NB_OFF-1:0]   o_best_offset,
  output logic [NB_WIN-1:0]   o_best_errors,
  output logic                o_relock
);

  localparam logic [NB_WIN-1:0] SETTLE_T = NB_WIN'(SETTLE_BITS);
  localparam logic [NB_WIN-1:0] WINDOW_T = NB_WIN'(WINDOW_BITS);
  localparam logic [NB_WIN-1:0] THRESH_T = NB_WIN'(LOCK_THRESH);
  localparam logic [NB_OFF-1:0] LAST_OFF = '1;

  state_t state, state_nxt;

  logic [NB_OFF-1:0] cand, cand_nxt;
  logic [NB_OFF-1:0] best_off, best_off_nxt;
  logic [NB_WIN-1:0] best_err, best_err_nxt;
  logic [NB_WIN-1:0] win_err, win_err_nxt;
  logic              in_lock, in_lock_nxt;   // SETTLE is a post-lock resync
  logic [NB_OFF-1:0] pub_off_nxt;
  logic [NB_WIN-1:0] pub_err_nxt;
  logic [NB_OFF-1:0] offset_nxt;
  logic              rx_en_nxt, busy_nxt, locked_nxt, relock_nxt;
  logic              better;

  logic              snap;
  logic              win_done;
  logic [NB_WIN-1:0] win_errs;
  logic [NB_WIN-1:0] target;

  // Settle windows use the short target; measure and check use the full one
  assign target = (state == ST_SETTLE) ? SETTLE_T : WINDOW_T;

  bit_window #(
    .NB_COUNT (NB_COUNT),
    .NB_WIN   (NB_WIN)
  ) u_win (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_snap        (snap),
    .i_bit_count   (i_bit_count),
    .i_error_count (i_error_count),
    .i_target      (target),
    .o_done        (win_done),
    .o_err         (win_errs)
  );

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Datapath and registered outputs, loaded from the next-state logic
  always_ff @(posedge clock) begin
    if (i_reset) begin
      cand          <= '0;
      best_off      <= '0;
      best_err      <= '1;
      win_err       <= '0;
      in_lock       <= 1'b0;
      o_offset      <= '0;
      o_rx_enable   <= 1'b0;
      o_busy        <= 1'b0;
      o_locked      <= 1'b0;
      o_best_offset <= '0;
      o_best_errors <= '0;
      o_relock      <= 1'b0;
    end else begin
      cand          <= cand_nxt;
      best_off      <= best_off_nxt;
      best_err      <= best_err_nxt;
      win_err       <= win_err_nxt;
      in_lock       <= in_lock_nxt;
      o_offset      <= offset_nxt;
      o_rx_enable   <= rx_en_nxt;
      o_busy        <= busy_nxt;
      o_locked      <= locked_nxt;
      o_best_offset <= pub_off_nxt;
      o_best_errors <= pub_err_nxt;
      o_relock      <= relock_nxt;
    end
  end

  // Next-state, best tracking and next output values
  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    best_off_nxt = best_off;
    best_err_nxt = best_err;
    win_err_nxt  = win_err;
    in_lock_nxt  = in_lock;
    pub_off_nxt  = o_best_offset;
    pub_err_nxt  = o_best_errors;
    relock_nxt   = 1'b0;
    snap         = 1'b0;
    better       = (win_err < best_err);

    case (state)
      ST_IDLE: begin
        if (i_enable) begin
          cand_nxt     = '0;
          best_off_nxt = '0;
          best_err_nxt = '1;
          in_lock_nxt  = 1'b0;
          state_nxt    = ST_SETTLE;
          snap         = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (win_done) begin
          state_nxt = in_lock ? ST_CHECK : ST_MEASURE;
          snap      = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (win_done) begin
          win_err_nxt = win_errs;
          state_nxt   = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Strict compare: on a tie the earlier (lower) offset is kept
        if (better) begin
          best_err_nxt = win_err;
          best_off_nxt = cand;
        end
        if (cand == LAST_OFF) begin
          pub_off_nxt = best_off_nxt;
          pub_err_nxt = best_err_nxt;
          state_nxt   = ST_LOCKED;
        end else begin
          cand_nxt  = cand + 1'b1;
          state_nxt = ST_SETTLE;
          snap      = 1'b1;
        end
      end
      ST_LOCKED: begin
        in_lock_nxt = 1'b1;
        state_nxt   = ST_SETTLE;
        snap        = 1'b1;
      end
      ST_CHECK: begin
        if (win_done) begin
          snap = 1'b1;
          if (win_errs > THRESH_T) begin
            relock_nxt   = 1'b1;
            in_lock_nxt  = 1'b0;
            cand_nxt     = '0;
            best_off_nxt = '0;
            best_err_nxt = '1;
            state_nxt    = ST_SETTLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Dropping enable aborts from anywhere; published results are retained
    if (!i_enable) begin
      state_nxt   = ST_IDLE;
      in_lock_nxt = 1'b0;
      relock_nxt  = 1'b0;
      snap        = 1'b0;
    end

    // Outputs reflect the state being entered so they change on that edge
    rx_en_nxt  = (state_nxt != ST_IDLE);
    locked_nxt = (state_nxt == ST_LOCKED) || (state_nxt == ST_CHECK) ||
                 ((state_nxt == ST_SETTLE) && in_lock_nxt);
    busy_nxt   = rx_en_nxt && !locked_nxt;
    offset_nxt = o_offset;
    if (rx_en_nxt) offset_nxt = locked_nxt ? best_off_nxt : cand_nxt;
  end

endmodule
